// File: rtl/tri_bus_arb_pkg.sv
// Shared types and helpers for the tri-state bus arbiter slice.
package tri_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_N_REQ       = 4;
  localparam int unsigned DEF_SLOT_CYCLES = 16;
  localparam int unsigned MAX_N_REQ       = 8;
  localparam int unsigned MAX_IDX_W       = 3;

  // Callers truncate the result to their own requester count.
  function automatic logic [MAX_N_REQ-1:0] onehot_from_idx(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_picker.sv
// Combinational round-robin search: first asserted request at or after ptr, wrapping.
module rr_picker
  import tri_bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] winner
);

  logic [IDX_W-1:0] idx;

  // Walk from the farthest offset down so the nearest match is written last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      idx = IDX_W'(ptr + IDX_W'(i - 1));
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state bus with bounded slots and turnaround.
// Optional slot lock: define TRI_BUS_ARB_LOCK_EN.
module tri_bus_arbiter
  import tri_bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = DEF_N_REQ,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned SLOT_CYCLES = DEF_SLOT_CYCLES,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bus_en,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] lock,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             bus_busy,
  output logic             turn
);

  arb_state_e       state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [IDX_W-1:0] gnt_idx_q;
  logic             busy_q;
  logic             turn_q;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             found;
  logic [IDX_W-1:0] winner;
  logic [N_REQ-1:0] own_oh;
  logic [N_REQ-1:0] win_oh;
  logic             others_pending;
  logic             expiry;
  logic             hold_slot;
  logic             release_bus;
  logic             take;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .found  (found),
    .winner (winner)
  );

`ifdef TRI_BUS_ARB_LOCK_EN
  assign hold_slot = lock[gnt_idx_q];
`else
  logic lock_unused;
  assign lock_unused = ^lock;
  assign hold_slot   = 1'b0;
`endif

  always_comb begin
    own_oh         = N_REQ'(onehot_from_idx(MAX_IDX_W'(gnt_idx_q)));
    win_oh         = N_REQ'(onehot_from_idx(MAX_IDX_W'(winner)));
    others_pending = |(req & ~own_oh);
    expiry         = (cnt_q == CNT_W'(SLOT_CYCLES - 1));
    release_bus    = !req[gnt_idx_q] || !bus_en || (expiry && others_pending && !hold_slot);
    take           = (state_q == IDLE || state_q == TURN) && bus_en && found;
    ptr_d          = IDX_W'(winner + 1'b1);
    // A locked owner at expiry with others waiting sits at the last count.
    if (expiry) cnt_d = others_pending ? cnt_q : '0;
    else        cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      busy_q    <= 1'b0;
      turn_q    <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else if (take) begin
      state_q   <= GRANT;
      gnt_q     <= win_oh;
      gnt_idx_q <= winner;
      busy_q    <= 1'b1;
      turn_q    <= 1'b0;
      ptr_q     <= ptr_d;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        GRANT: begin
          if (release_bus) begin
            state_q <= TURN;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            turn_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_d;
          end
        end
        TURN: begin
          state_q <= IDLE;
          turn_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          turn_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign gnt_idx  = gnt_idx_q;
  assign bus_busy = busy_q;
  assign turn     = turn_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Scoreboard bench for tri_bus_arbiter: per-cycle expected outputs are queued by stimulus.
module tb_tri_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bus_en = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] lock = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       bus_busy;
  logic       turn;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       busy;
    logic       turn;
    string      tag;
  } exp_t;

  exp_t sb[$];

  tri_bus_arbiter #(
    .N_REQ       (4),
    .IDX_W       (2),
    .SLOT_CYCLES (16),
    .CNT_W       (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_en   (bus_en),
    .req      (req),
    .lock     (lock),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .bus_busy (bus_busy),
    .turn     (turn)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input logic r_n, input logic en, input logic [3:0] rq, input logic [3:0] lk,
                      input logic [3:0] eg, input logic [1:0] ei, input logic et, input string tag);
    exp_t e;
    @(negedge clk);
    rst_n  = r_n;
    bus_en = en;
    req    = rq;
    lock   = lk;
    e.gnt  = eg;
    e.idx  = ei;
    e.busy = |eg;
    e.turn = et;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic rep(input int n, input logic r_n, input logic en, input logic [3:0] rq,
                     input logic [3:0] lk, input logic [3:0] eg, input logic [1:0] ei,
                     input logic et, input string tag);
    for (int i = 0; i < n; i++) step(r_n, en, rq, lk, eg, ei, et, tag);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (gnt !== e.gnt || gnt_idx !== e.idx || bus_busy !== e.busy || turn !== e.turn) begin
          failures++;
          $display("FAIL %s: got gnt=%b idx=%0d busy=%b turn=%b, want gnt=%b idx=%0d busy=%b turn=%b",
                   e.tag, gnt, gnt_idx, bus_busy, turn, e.gnt, e.idx, e.busy, e.turn);
        end
        checks++;
        if (!$onehot0(gnt)) begin
          failures++;
          $display("FAIL onehot0 (%s): got gnt=%b, want zero or one-hot", e.tag, gnt);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin : stimulus
    int drain;
    // Reset with all requests asserted
    rep(3, 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, "reset");
    // Rotation 0,1,2,3,0 with 16-cycle tenures and one turnaround between
    step(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0, "first_grant");
    rep(15, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0, "rot_0");
    step(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b1, "rot_turn0");
    rep(16, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0, "rot_1");
    step(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd1, 1'b1, "rot_turn1");
    rep(16, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b0, "rot_2");
    step(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd2, 1'b1, "rot_turn2");
    rep(16, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0, "rot_3");
    step(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd3, 1'b1, "rot_turn3");
    step(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0, "rot_wrap0");
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, "rot_release");
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, "rot_idle");
    // Early release: source 2 drops at slot_cnt=5
    rep(6, 1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, "early_own2");
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b1, "early_turn");
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, "early_idle");
    step(1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, "late_req0");
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, "late_turn");
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, "late_idle");
    // Sole requester keeps the bus across slot wraps
    rep(40, 1'b1, 1'b1, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, "sole_3");
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b1, "sole_turn");
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, "sole_idle");
    // bus_en drop mid-tenure, blocked while low, resumes from pointer (2 -> source 0)
    rep(4, 1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, "en_own1");
    step(1'b1, 1'b0, 4'b0011, 4'b0000, 4'b0000, 2'd1, 1'b1, "en_turn");
    rep(3, 1'b1, 1'b0, 4'b0011, 4'b0000, 4'b0000, 2'd1, 1'b0, "en_blocked");
    rep(16, 1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0, "en_resume0");
    step(1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0000, 2'd0, 1'b1, "en_turn2");
    step(1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b0, "en_next1");
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b1, "en_rel");
    step(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, "en_idle_low");
    // Reset mid-tenure: no turnaround, pointer returns to 0
    step(1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, "rst_own2");
    step(1'b0, 1'b1, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0, "rst_mid");
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, "rst_idle");
    step(1'b1, 1'b1, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b0, "rst_ptr0");
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, "rst_rel");
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, "rst_idle2");
    // Lock on owner 1 with source 3 waiting
    step(1'b1, 1'b1, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b0, "lock_own1");
`ifdef TRI_BUS_ARB_LOCK_EN
    rep(19, 1'b1, 1'b1, 4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b0, "lock_hold");
    step(1'b1, 1'b1, 4'b1010, 4'b0000, 4'b0000, 2'd1, 1'b1, "lock_turn");
`else
    rep(15, 1'b1, 1'b1, 4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b0, "lock_ignored");
    step(1'b1, 1'b1, 4'b1010, 4'b0010, 4'b0000, 2'd1, 1'b1, "lock_turn");
`endif
    step(1'b1, 1'b1, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, "lock_next3");
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b1, "lock_rel");
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, "lock_idle");

    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      @(posedge clk);
      #2;
      drain++;
    end
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tri_bus_arbiter.md
Name: tri_bus_arbiter

Overview:
Round-robin arbiter for a shared tri-state data bus driven by N_REQ sources, each behind its own tri-state buffer.
- Issues one-hot output-enables so at most one source drives the bus.
- Bounds each tenure to a slot of SLOT_CYCLES clocks.
- Inserts an all-off turnaround cycle between owners to prevent contention.
- Sits between the requesting sources and the tristate/decode/LED display path; gnt_idx feeds the decoder select.

Parameters:
N_REQ, 4, number of requesters (power of two, 2..8)
IDX_W, 2, width of grant index, log2(N_REQ)
SLOT_CYCLES, 16, maximum clocks per tenure while others wait (>=2)
CNT_W, 4, slot counter width, must hold SLOT_CYCLES-1

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
bus_en  in  1  global bus enable; low forces release and blocks new grants
req  in  N_REQ  per-source request, level-held until served
lock  in  N_REQ  per-source slot-extension request (used only with LOCK_EN)
gnt  out  N_REQ  one-hot tri-state output-enable, registered
gnt_idx  out  IDX_W  binary index of current/last owner, registered
bus_busy  out  1  high while in GRANT
turn  out  1  high during the turnaround cycle

Behaviour:
- Reset: clk rising with rst_n=0 forces the following, regardless of state:
  - state=IDLE, gnt=0, gnt_idx=0, bus_busy=0, turn=0
  - rr pointer=0, slot_cnt=0
- Reset mid-tenure drops gnt in that same clock edge; no turnaround is emitted.
- States are IDLE, GRANT and TURN.
- IDLE: gnt=0.
  - If bus_en && |req, pick a winner by round-robin and go to GRANT next edge.
  - Latency from req sampled high to gnt high is 1 clock.
- Round-robin: search starts at pointer and wraps modulo N_REQ; the first asserted req wins.
  - On grant: pointer<=winner+1 (wraps), gnt_idx<=winner, slot_cnt<=0.
- GRANT: gnt=onehot(gnt_idx), bus_busy=1, slot_cnt increments each clock, saturating at SLOT_CYCLES-1.
  - Go to TURN when any of:
    - (a) req[gnt_idx]=0
    - (b) bus_en=0
    - (c) slot_cnt==SLOT_CYCLES-1 and any other req pending
  - At expiry with no other req pending, slot_cnt<=0 and the owner keeps the bus.
- TURN: exactly one clock, gnt=0, turn=1.
  - Arbitration is evaluated in this cycle, so the next edge goes to GRANT (new winner) if bus_en && |req, else IDLE.
  - The previous owner may win again only if it is the sole requester.
- Invariants:
  - gnt is always 0 or one-hot.
  - gnt never changes owner without an intervening all-zero cycle.
- Simultaneous events: if (a) and (c) occur in the same cycle, the result is a single TURN.
- bus_en falling in IDLE: no effect.

Optional Feature:
Macro TRI_BUS_ARB_LOCK_EN.
- Defined: in GRANT, lock[gnt_idx]=1 suppresses condition (c); the owner keeps the bus past slot expiry until req or lock drops.
  - bus_en=0 still forces release.
  - lock of non-owners is ignored.
- Undefined: the lock port exists but is ignored; slots are always enforced.

Decomposition:
- Package tri_bus_arb_pkg holds:
  - state enum {IDLE, GRANT, TURN}
  - default N_REQ/SLOT_CYCLES constants
  - onehot-from-index function
- One combinational sub-module, rr_picker:
  - inputs: req, pointer
  - outputs: found, winner index
- The FSM, counter and pointer stay in tri_bus_arbiter.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> gnt=0, gnt_idx=0, bus_busy=0; first grant after release is source 0, 1 clock after rst_n=1.
- Rotation: req=4'b1111 held, SLOT_CYCLES=16 -> grant order 0,1,2,3,0.
  - Each tenure is 16 clocks, with exactly one turn=1, gnt=0 cycle between tenures.
- Early release: source 2 is sole owner, req[2] drops at slot_cnt=5 -> TURN on the next edge, then IDLE if no req.
  - A later req=4'b0001 is granted to source 0 one clock after sampling.
- Sole requester: req=4'b1000 held for 40 clocks -> gnt=4'b1000 continuously, no turnaround, slot_cnt wraps at 15.
- bus_en: deassert mid-tenure -> TURN, then IDLE with gnt=0 while bus_en=0 despite pending req; reassert -> grant resumes from the rr pointer.
- LOCK_EN built: owner 1 with lock[1]=1 and req[3]=1 -> owner 1 retained past 16 clocks; lock[1] drop at expiry -> TURN, then gnt=4'b1000.
